// File: rtl/tff_sched_pkg.sv
// Shared defaults and the round-robin pick used by the toggle scheduler.
package tff_sched_pkg;

    localparam int unsigned NReqDefault  = 4;
    localparam int unsigned WidthDefault = 8;
    localparam int unsigned MaxReq       = 8;
    localparam int unsigned MaxPtrW      = $clog2(MaxReq);
    localparam int unsigned PTR_W        = $clog2(NReqDefault);

    // One-hot pick of the first set req at or above ptr, wrapping at n_req.
    function automatic logic [MaxReq-1:0] rr_pick(input logic [MaxReq-1:0]  req,
                                                  input logic [MaxPtrW-1:0] ptr,
                                                  input int unsigned        n_req);
        logic [MaxReq-1:0] pick;
        logic              found;
        logic [MaxPtrW:0]  idx;
        pick  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MaxReq; k++) begin
            if (k < n_req) begin
                idx = {1'b0, ptr} + (MaxPtrW + 1)'(k);
                if (idx >= (MaxPtrW + 1)'(n_req)) begin
                    idx = idx - (MaxPtrW + 1)'(n_req);
                end
                if (!found && req[idx[MaxPtrW-1:0]]) begin
                    pick[idx[MaxPtrW-1:0]] = 1'b1;
                    found                  = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/tff_bank.sv
// Bank of WIDTH T flip-flops: each bit inverts on a rising edge when its t bit is set.
module tff_bank #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] t_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q ^ t_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/tff_toggle_sched.sv
// Round-robin arbiter granting one requester per cycle; the winner's mask is registered
// as the pending T-vector and applied to the shared toggle bank on the following edge.
module tff_toggle_sched
    import tff_sched_pkg::*;
#(
    parameter int unsigned N_REQ = NReqDefault,
    parameter int unsigned WIDTH = WidthDefault
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [N_REQ-1:0]       req_i,
    input  logic [N_REQ*WIDTH-1:0] mask_i,
    input  logic                   hold_i,
    output logic [N_REQ-1:0]       gnt_o,
    output logic [WIDTH-1:0]       q_o,
    output logic                   idle_o
);

    localparam int unsigned PtrW = $clog2(N_REQ);

    logic [PtrW-1:0]   ptr_q, ptr_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [WIDTH-1:0]  t_q, t_d;
    logic [MaxReq-1:0] req_ext, pick;

    assign req_ext = MaxReq'(req_i);
    assign pick    = rr_pick(req_ext, MaxPtrW'(ptr_q), N_REQ);

    always_comb begin
        gnt_d = '0;
        t_d   = '0;
        ptr_d = ptr_q;
        if (!hold_i && |req_i) begin
            gnt_d = pick[N_REQ-1:0];
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (pick[i]) begin
                    t_d   = mask_i[i*WIDTH +: WIDTH];
                    ptr_d = (i == N_REQ - 1) ? '0 : PtrW'(i + 1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gnt_q <= '0;
            t_q   <= '0;
            ptr_q <= '0;
        end else begin
            gnt_q <= gnt_d;
            t_q   <= t_d;
            ptr_q <= ptr_d;
        end
    end

    // Pending T-vector is applied regardless of hold, so a grant is never lost.
    tff_bank #(
        .WIDTH(WIDTH)
    ) u_bank (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .t_i   (t_q),
        .q_o   (q_o)
    );

    assign gnt_o  = gnt_q;
    assign idle_o = (gnt_q == '0) && (t_q == '0);

endmodule

// File: tb/tb_tff_toggle_sched.sv
// Randomised and directed checks of tff_toggle_sched against a behavioural scheduler model.
module tb_tff_toggle_sched;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] mask = '0;
    logic           hold = 1'b0;
    logic [N-1:0]   gnt;
    logic [W-1:0]   q;
    logic           idle;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: pointer as plain integer, pending toggle, bank value.
    int           m_ptr = 0;
    logic [N-1:0] m_gnt = '0;
    logic [W-1:0] m_t   = '0;
    logic [W-1:0] m_q   = '0;

    tff_toggle_sched #(
        .N_REQ(N),
        .WIDTH(W)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .req_i (req),
        .mask_i(mask),
        .hold_i(hold),
        .gnt_o (gnt),
        .q_o   (q),
        .idle_o(idle)
    );

    always #5 clk = ~clk;

    function automatic logic m_idle();
        return (m_gnt == '0) && (m_t == '0);
    endfunction

    task automatic model_reset();
        m_ptr = 0;
        m_gnt = '0;
        m_t   = '0;
        m_q   = '0;
    endtask

    // Advance one edge: model consumes the inputs present at the edge; returns 1ns later.
    task automatic tick();
        logic [W-1:0] nq;
        int           w;
        @(posedge clk);
        if (rst_n) begin
            nq = m_q ^ m_t;
            w  = -1;
            if (!hold) begin
                for (int k = 0; k < N; k++) begin
                    if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                end
            end
            if (w >= 0) begin
                m_gnt = N'(1 << w);
                m_t   = mask[w*W +: W];
                m_ptr = (w + 1) % N;
            end else begin
                m_gnt = '0;
                m_t   = '0;
            end
            m_q = nq;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        hold  = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b1111;
        mask  = {4{8'hFF}};
        model_reset();
        for (int c = 0; c < 2; c++) begin
            tick();
            n_checks++;
            if ({gnt, q, idle} !== {4'b0000, 8'h00, 1'b1}) begin
                n_fail++;
                $display("FAIL reset_hold: got gnt=%b q=%h idle=%b want 0000 00 1", gnt, q, idle);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        req   = '0;
        tick();
        n_checks++;
        if ({gnt, q, idle} !== {4'b0000, 8'h00, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_release: got gnt=%b q=%h idle=%b want 0000 00 1", gnt, q, idle);
        end
        // Pointer must start at 0: full request picks requester 0.
        req = 4'b1111;
        tick();
        req = '0;
        n_checks++;
        if (gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_pointer: got gnt=%b want 0001", gnt);
        end
        tick();
        tick();
    endtask

    task automatic test_single();
        logic [W-1:0] q0;
        do_reset();
        mask          = '0;
        mask[2*W +: W] = 8'hA5;
        for (int r = 0; r < 2; r++) begin
            q0  = q;
            req = 4'b0100;
            tick();
            req = '0;
            n_checks++;
            if (gnt !== 4'b0100 || idle !== 1'b0) begin
                n_fail++;
                $display("FAIL single_gnt: got gnt=%b idle=%b want 0100 0", gnt, idle);
            end
            tick();
            n_checks++;
            if (gnt !== 4'b0000 || q !== (q0 ^ 8'hA5) || q !== m_q) begin
                n_fail++;
                $display("FAIL single_q: got gnt=%b q=%h want 0000 %h", gnt, q, q0 ^ 8'hA5);
            end
        end
        n_checks++;
        if (q !== 8'h00) begin
            n_fail++;
            $display("FAIL single_repeat: got q=%h want 00", q);
        end
    endtask

    task automatic test_rotation();
        logic [W-1:0] exp_q [8] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h0E, 8'h0C, 8'h08, 8'h00};
        do_reset();
        for (int i = 0; i < N; i++) mask[i*W +: W] = W'(1 << i);
        req = 4'b1111;
        tick();
        for (int c = 0; c < 8; c++) begin
            n_checks++;
            if (gnt !== N'(1 << (c % N)) || gnt !== m_gnt) begin
                n_fail++;
                $display("FAIL rotation_gnt[%0d]: got %b want %b", c, gnt, N'(1 << (c % N)));
            end
            if (c == 7) req = '0;
            tick();
            n_checks++;
            if (q !== exp_q[c]) begin
                n_fail++;
                $display("FAIL rotation_q[%0d]: got %h want %h", c, q, exp_q[c]);
            end
        end
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        req = 4'b1000;
        tick();
        req = 4'b1001;
        tick();
        req = '0;
        n_checks++;
        if (gnt !== 4'b0001 || gnt !== m_gnt) begin
            n_fail++;
            $display("FAIL wrap_priority: got %b want 0001", gnt);
        end
        tick();
        tick();
    endtask

    task automatic test_hold();
        do_reset();
        mask          = '0;
        mask[1*W +: W] = 8'h0F;
        req = 4'b0010;
        tick();
        n_checks++;
        if (gnt !== 4'b0010) begin
            n_fail++;
            $display("FAIL hold_grant: got %b want 0010", gnt);
        end
        hold = 1'b1;
        req  = 4'b0011;
        tick();
        n_checks++;
        if (q !== 8'h0F || gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL hold_toggle: got q=%h gnt=%b want 0f 0000", q, gnt);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (gnt !== 4'b0000 || idle !== 1'b1) begin
                n_fail++;
                $display("FAIL hold_nogrant: got gnt=%b idle=%b want 0000 1", gnt, idle);
            end
        end
        hold = 1'b0;
        tick();
        req = '0;
        // Pointer sits at 2, so among {0,1} requester 0 is reached first.
        n_checks++;
        if (gnt !== 4'b0001 || gnt !== m_gnt) begin
            n_fail++;
            $display("FAIL hold_resume: got %b want 0001", gnt);
        end
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        mask          = '0;
        mask[0 +: W]  = 8'hFF;
        req = 4'b0001;
        tick();
        req = '0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({gnt, q, idle} !== {4'b0000, 8'h00, 1'b1}) begin
            n_fail++;
            $display("FAIL midreset_clear: got gnt=%b q=%h idle=%b want 0000 00 1", gnt, q, idle);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (q !== 8'h00 || gnt !== 4'b0000) begin
                n_fail++;
                $display("FAIL midreset_noflight[%0d]: got q=%h gnt=%b want 00 0000", c, q, gnt);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 300; c++) begin
            req  = N'($urandom);
            hold = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < N; i++) begin
                mask[i*W +: W] = ($urandom_range(0, 7) == 0) ? 8'h00 : W'($urandom);
            end
            tick();
            n_checks++;
            if ({gnt, q, idle} !== {m_gnt, m_q, m_idle()}) begin
                n_fail++;
                $display("FAIL random[%0d]: got gnt=%b q=%h idle=%b want %b %h %b",
                         c, gnt, q, idle, m_gnt, m_q, m_idle());
            end
        end
        req  = '0;
        hold = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_wrap();
        test_hold();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tff_toggle_sched.md
# tff_toggle_sched

Round-robin scheduler that shares a WIDTH-bit bank of T flip-flops between N_REQ requesters. Each requester presents a toggle mask; the scheduler grants one requester per cycle and drives the winner's mask as the T-vector into the bank, so the granted bits of q invert one edge later. It sits between requesting control logic and the shared toggle-state register.

## Interface
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 8, width of the toggle register bank
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- req  input  N_REQ  request per requester; level, held until granted
- mask  input  N_REQ*WIDTH  toggle mask; requester i uses bits [i*WIDTH +: WIDTH]
- hold  input  1  when 1, no new grants are issued
- gnt  output  N_REQ  registered one-hot grant, high for one cycle per grant
- q  output  WIDTH  toggle bank state
- idle  output  1  1 when gnt == 0 and no toggle is pending

## Operation
- Reset (reset == 0, asynchronous): gnt = 0, pending T-vector = 0, q = 0, priority pointer = 0 (requester 0 highest), idle = 1.
- Arbitration at each posedge with reset == 1 and hold == 0:
  - The winner is the first asserted req searching from pointer upward, with wrap.
  - gnt is set to the one-hot winner.
  - The pending T-vector is set to the winner's mask.
  - The pointer is set to winner+1 mod N_REQ.
- If no req is asserted, or hold == 1: gnt = 0, pending T-vector = 0, pointer unchanged.
- Toggle stage, at each posedge: q <= q ^ pending T-vector. The toggle registered at edge k is applied at edge k+1, regardless of hold.
- Handshake:
  - A requester sees gnt high for exactly one cycle.
  - It must drop req during that cycle if it wants only one toggle.
  - A req still high at the next edge is a new request and is arbitrated normally; under the rotated pointer it is not favoured.
- A granted mask of all zeros is legal. It consumes a grant slot and leaves q unchanged.
- idle = (gnt == 0) && (pending T-vector == 0). idle is combinational from registers.

## Timing
- Latency: req sampled at edge k → gnt high in cycle k..k+1 → q updated at edge k+1. From req to q change is 2 edges.
- Throughput: one grant per cycle. Back-to-back grants to different requesters toggle q on consecutive edges.
- Fairness: with all N_REQ requesting continuously, grants rotate 0,1,...,N_REQ-1,0,... and no requester waits more than N_REQ cycles.
- Simultaneous events:
  - hold rising in the same cycle as a grant does not cancel that grant's toggle.
  - mask may change freely while req is low. It is sampled only at the granting edge.
- Reset mid-operation: an asserted reset immediately clears q, gnt and the pending T-vector. A toggle in flight is dropped. The first grant after release follows the rule for pointer = 0.
- All outputs are registered except idle.

## Structure
- Package tff_sched_pkg holds:
  - default N_REQ and WIDTH;
  - localparam PTR_W = $clog2(N_REQ);
  - a function that performs a round-robin pick, returning a one-hot vector from req and pointer.
- Sub-module tff_bank: WIDTH T flip-flops with inputs clk, reset (active-low async) and t[WIDTH], and output q[WIDTH]. It is instantiated once.
- The arbiter and pointer live in the top module.

## Test plan
- Reset and idle:
  - Stimulus: hold reset low for 2 cycles with req = 4'b1111; then release it with req = 0.
  - Required response: gnt = 0, q = 8'h00 and idle = 1 throughout; pointer = 0.
- Single toggle:
  - Stimulus: req = 4'b0100, mask2 = 8'hA5; drop req when gnt is seen.
  - Required response: gnt = 4'b0100 for one cycle; q = 8'hA5 one edge later; a repeat gives q = 8'h00.
- Rotation:
  - Stimulus: req = 4'b1111 held for 8 cycles, mask_i = 1 << i.
  - Required response: grant order 0,1,2,3,0,1,2,3; q cycles 01,03,07,0F,0E,0C,08,00.
- Wrap priority:
  - Stimulus: grant requester 3; then apply req = 4'b1001.
  - Required response: requester 0 wins next.
- Hold:
  - Stimulus: raise hold in the same cycle as gnt = 4'b0010 with mask1 = 8'h0F.
  - Required response: q still toggles to 8'h0F; no gnt while hold = 1; the grant resumes at the pointer after hold drops.
- Reset mid-flight:
  - Stimulus: assert reset asynchronously between the grant edge and the toggle edge, with mask = 8'hFF.
  - Required response: q stays 8'h00 and no toggle appears after release.
